// File: rtl/tron_trail_sequencer.sv
// Sole master of the 1-bit trail BRAM: clears the arena, then per game tick
// reads both head cells, latches deaths and marks both cells as trail.
module tron_trail_sequencer #(
  parameter int unsigned GRID_W     = 160,
  parameter int unsigned GRID_H     = 120,
  parameter int unsigned CELL_SHIFT = 2,
  parameter int unsigned ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              tick,
  input  logic [9:0]        x1,
  input  logic [9:0]        y1,
  input  logic [9:0]        x2,
  input  logic [9:0]        y2,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_wdata,
  input  logic              mem_rdata,
  output logic              ready,
  output logic              step_done,
  output logic              dead1,
  output logic              dead2
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned CELLS = GRID_W * GRID_H;

  typedef enum logic [2:0] {
    S_CLEAR, S_READY, S_RD1, S_RD2, S_EVAL, S_WR1, S_WR2, S_DONE
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr1_q, addr2_q, mem_addr_q;
  logic              oob1_q, oob2_q, same_q, occ1_q;
  logic              mem_we_q, mem_wdata_q, ready_q, step_done_q, dead1_q, dead2_q;

  // Cell addresses straight from the head coordinates; latched on tick acceptance.
  logic [9:0]        cx1, cy1, cx2, cy2;
  logic [ADDR_W-1:0] addr1_d, addr2_d;
  logic              oob1_d, oob2_d, same_d;

  assign cx1     = x1 >> CELL_SHIFT;
  assign cy1     = y1 >> CELL_SHIFT;
  assign cx2     = x2 >> CELL_SHIFT;
  assign cy2     = y2 >> CELL_SHIFT;
  assign addr1_d = ADDR_W'(cy1) * ADDR_W'(GRID_W) + ADDR_W'(cx1);
  assign addr2_d = ADDR_W'(cy2) * ADDR_W'(GRID_W) + ADDR_W'(cx2);
  assign oob1_d  = (32'(cx1) >= GRID_W) || (32'(cy1) >= GRID_H);
  assign oob2_d  = (32'(cx2) >= GRID_W) || (32'(cy2) >= GRID_H);
  assign same_d  = !oob1_d && !oob2_d && (addr1_d == addr2_d);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_CLEAR;
      cnt_q       <= '0;
      addr1_q     <= '0;
      addr2_q     <= '0;
      oob1_q      <= 1'b0;
      oob2_q      <= 1'b0;
      same_q      <= 1'b0;
      occ1_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 1'b0;
      ready_q     <= 1'b0;
      step_done_q <= 1'b0;
      dead1_q     <= 1'b0;
      dead2_q     <= 1'b0;
    end else if (start) begin
      // A new round abandons whatever step is in flight.
      state_q     <= S_CLEAR;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 1'b0;
      ready_q     <= 1'b0;
      step_done_q <= 1'b0;
      dead1_q     <= 1'b0;
      dead2_q     <= 1'b0;
    end else begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 1'b0;
      ready_q     <= 1'b0;
      step_done_q <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          if (cnt_q == CNT_W'(CELLS)) begin
            state_q <= S_READY;
            ready_q <= 1'b1;
          end else begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= ADDR_W'(cnt_q);
            cnt_q      <= cnt_q + CNT_W'(1);
          end
        end
        S_READY: begin
          if (tick && !dead1_q && !dead2_q) begin
            state_q    <= S_RD1;
            addr1_q    <= addr1_d;
            addr2_q    <= addr2_d;
            oob1_q     <= oob1_d;
            oob2_q     <= oob2_d;
            same_q     <= same_d;
            mem_addr_q <= addr1_d;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_RD1: begin
          state_q    <= S_RD2;
          mem_addr_q <= addr2_q;
        end
        S_RD2: begin
          state_q <= S_EVAL;
          occ1_q  <= mem_rdata;
        end
        S_EVAL: begin
          state_q <= S_WR1;
          dead1_q <= dead1_q | occ1_q | oob1_q | same_q;
          dead2_q <= dead2_q | mem_rdata | oob2_q | same_q;
          if (!oob1_q) begin
            mem_we_q    <= 1'b1;
            mem_wdata_q <= 1'b1;
            mem_addr_q  <= addr1_q;
          end
        end
        S_WR1: begin
          state_q <= S_WR2;
          if (!oob2_q) begin
            mem_we_q    <= 1'b1;
            mem_wdata_q <= 1'b1;
            mem_addr_q  <= addr2_q;
          end
        end
        S_WR2: begin
          state_q     <= S_DONE;
          step_done_q <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_READY;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_CLEAR;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign ready     = ready_q;
  assign step_done = step_done_q;
  assign dead1     = dead1_q;
  assign dead2     = dead2_q;

endmodule
